// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit pipelined core: datapath width and WB source encodings.
package core_pkg;

    localparam int unsigned DATA_W = 8;

    // Write-back source select driven by MemToReg.
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_IN  = 2'b10,
        WB_PC  = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/data_mem.sv
// Data/stack memory: asynchronous clear, synchronous write, asynchronous read.
// A read and write to the same address in one cycle returns the old contents.
module data_mem
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DW     = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DW-1:0] mem_q [Depth];

    // Storage array; reset wipes every byte so the stack starts clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Asynchronous read port.
    always_comb begin
        rdata = mem_q[addr];
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register: data memory access, stack push/pop for
// CALL/interrupt/RET, OUT-port register and the registered write-back/redirect outputs.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DW     = DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pc_plus1,
    input  logic [DW-1:0] Rd1,
    input  logic [DW-1:0] Rd2,
    input  logic          IO_Write,
    input  logic [1:0]    RegDistidx,
    input  logic [DW-1:0] ALU_res,
    input  logic [DW-1:0] FW_value,
    input  logic          MemWrite,
    input  logic [1:0]    MemToReg,
    input  logic          RegWrite,
    input  logic [DW-1:0] IP,
    input  logic          isCall,
    input  logic          int_signal,
    input  logic          isNotRet,
    input  logic [DW-1:0] in_port,
    input  logic          flush,
    output logic [DW-1:0] mem_fwd_data,
    output logic [DW-1:0] wb_data,
    output logic [1:0]    RegDistidx_out,
    output logic          RegWrite_out,
    output logic [DW-1:0] ret_pc,
    output logic          ret_valid,
    output logic [DW-1:0] out_port,
    output logic [DW-1:0] Rd1_out,
    output logic [DW-1:0] Rd2_out
);

    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [1:0]    rdist_q, rdist_d;
    logic          reg_write_q, reg_write_d;
    logic [DW-1:0] ret_pc_q, ret_pc_d;
    logic          ret_valid_q, ret_valid_d;
    logic [DW-1:0] out_port_q, out_port_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic [DW-1:0] rd2_q, rd2_d;

    // Write enable and data: interrupt push beats CALL push beats a plain store.
    always_comb begin
        mem_we = (MemWrite | isCall | int_signal) & ~flush;
        if (int_signal) begin
            mem_wdata = IP;
        end else if (isCall) begin
            mem_wdata = pc_plus1;
        end else begin
            mem_wdata = FW_value;
        end
    end

    data_mem #(
        .ADDR_W (ADDR_W),
        .DW     (DW)
    ) u_data_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .addr  (ALU_res[ADDR_W-1:0]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Write-back source mux; also feeds MEM-to-EX forwarding in the same cycle.
    always_comb begin
        mem_fwd_data = ALU_res;
        unique case (MemToReg)
            WB_ALU: mem_fwd_data = ALU_res;
            WB_MEM: mem_fwd_data = mem_rdata;
            WB_IN:  mem_fwd_data = in_port;
            WB_PC:  mem_fwd_data = pc_plus1;
        endcase
    end

    // Next-state for MEM/WB register; flush only kills the control bits.
    always_comb begin
        wb_data_d   = mem_fwd_data;
        rdist_d     = RegDistidx;
        rd1_d       = Rd1;
        rd2_d       = Rd2;
        reg_write_d = RegWrite & ~flush;
        ret_valid_d = ~isNotRet & ~flush;
        ret_pc_d    = mem_rdata;
        out_port_d  = out_port_q;
        if (IO_Write && !flush) begin
            out_port_d = FW_value;
        end
    end

    // MEM/WB pipeline register and OUT-port register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_data_q   <= '0;
            rdist_q     <= '0;
            reg_write_q <= 1'b0;
            ret_pc_q    <= '0;
            ret_valid_q <= 1'b0;
            out_port_q  <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
        end else begin
            wb_data_q   <= wb_data_d;
            rdist_q     <= rdist_d;
            reg_write_q <= reg_write_d;
            ret_pc_q    <= ret_pc_d;
            ret_valid_q <= ret_valid_d;
            out_port_q  <= out_port_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
        end
    end

    // Drive registered outputs.
    always_comb begin
        wb_data        = wb_data_q;
        RegDistidx_out = rdist_q;
        RegWrite_out   = reg_write_q;
        ret_pc         = ret_pc_q;
        ret_valid      = ret_valid_q;
        out_port       = out_port_q;
        Rd1_out        = rd1_q;
        Rd2_out        = rd2_q;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, async reset sequence, random vs. model.
module tb_mem_wb_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pc_plus1, Rd1, Rd2, ALU_res, FW_value, IP, in_port;
    logic       IO_Write, MemWrite, RegWrite, isCall, int_signal, isNotRet, flush;
    logic [1:0] RegDistidx, MemToReg;
    logic [7:0] mem_fwd_data, wb_data, ret_pc, out_port, Rd1_out, Rd2_out;
    logic [1:0] RegDistidx_out;
    logic       RegWrite_out, ret_valid;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc_plus1       (pc_plus1),
        .Rd1            (Rd1),
        .Rd2            (Rd2),
        .IO_Write       (IO_Write),
        .RegDistidx     (RegDistidx),
        .ALU_res        (ALU_res),
        .FW_value       (FW_value),
        .MemWrite       (MemWrite),
        .MemToReg       (MemToReg),
        .RegWrite       (RegWrite),
        .IP             (IP),
        .isCall         (isCall),
        .int_signal     (int_signal),
        .isNotRet       (isNotRet),
        .in_port        (in_port),
        .flush          (flush),
        .mem_fwd_data   (mem_fwd_data),
        .wb_data        (wb_data),
        .RegDistidx_out (RegDistidx_out),
        .RegWrite_out   (RegWrite_out),
        .ret_pc         (ret_pc),
        .ret_valid      (ret_valid),
        .out_port       (out_port),
        .Rd1_out        (Rd1_out),
        .Rd2_out        (Rd2_out)
    );

    typedef struct {
        logic       mw, call, intr, nr, io, rw, fl;
        logic [1:0] m2r, rdist;
        logic [7:0] alu, fw, pc1, ip, inp;
        logic [7:0] e_fwd, e_wb, e_rpc, e_out;
        logic       e_rw, e_rv;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(
        input logic mw, input logic call, input logic intr, input logic nr, input logic io,
        input logic rw, input logic fl, input logic [1:0] m2r, input logic [1:0] rdist,
        input logic [7:0] alu, input logic [7:0] fw, input logic [7:0] pc1,
        input logic [7:0] ip, input logic [7:0] inp, input logic [7:0] e_fwd,
        input logic [7:0] e_wb, input logic e_rw, input logic e_rv,
        input logic [7:0] e_rpc, input logic [7:0] e_out);
        vec_t r;
        r.mw = mw; r.call = call; r.intr = intr; r.nr = nr; r.io = io; r.rw = rw; r.fl = fl;
        r.m2r = m2r; r.rdist = rdist; r.alu = alu; r.fw = fw; r.pc1 = pc1; r.ip = ip;
        r.inp = inp; r.e_fwd = e_fwd; r.e_wb = e_wb; r.e_rw = e_rw; r.e_rv = e_rv;
        r.e_rpc = e_rpc; r.e_out = e_out;
        return r;
    endfunction

    task automatic drive(input vec_t x, input logic [7:0] r1, input logic [7:0] r2);
        MemWrite = x.mw; isCall = x.call; int_signal = x.intr; isNotRet = x.nr;
        IO_Write = x.io; RegWrite = x.rw; flush = x.fl; MemToReg = x.m2r;
        RegDistidx = x.rdist; ALU_res = x.alu; FW_value = x.fw; pc_plus1 = x.pc1;
        IP = x.ip; in_port = x.inp; Rd1 = r1; Rd2 = r2;
    endtask

    task automatic idle();
        drive(v(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                0, 0, 0, 0, 0, 0), 8'h00, 8'h00);
    endtask

    // Reads a byte combinationally through the MEM forwarding path (no write).
    task automatic peek(input string name, input logic [7:0] addr, input logic [7:0] exp);
        @(negedge clk);
        idle();
        MemToReg = 2'b01;
        ALU_res  = addr;
        #1 chk(name, mem_fwd_data, exp);
    endtask

    vec_t       tbl[$];
    logic [7:0] mem_m [256];
    logic [7:0] out_m;

    initial begin
        // mw call intr nr io rw fl m2r rdist alu fw pc1 ip inp | fwd wb rw rv rpc out
        tbl.push_back(v(1,0,0,1,0,0,0,2'b00,2'd0,8'h10,8'hA5,8'h00,8'h00,8'h00, 8'h10,8'h10,0,0,8'h00,8'h00));
        tbl.push_back(v(0,0,0,1,0,1,0,2'b01,2'd2,8'h10,8'h00,8'h00,8'h00,8'h00, 8'hA5,8'hA5,1,0,8'hA5,8'h00));
        tbl.push_back(v(0,1,0,1,0,0,0,2'b00,2'd1,8'hFF,8'h00,8'h34,8'h00,8'h00, 8'hFF,8'hFF,0,0,8'h00,8'h00));
        tbl.push_back(v(0,0,0,0,0,0,0,2'b00,2'd0,8'hFF,8'h00,8'h00,8'h00,8'h00, 8'hFF,8'hFF,0,1,8'h34,8'h00));
        tbl.push_back(v(0,0,0,1,0,0,0,2'b00,2'd0,8'h00,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,8'h00,8'h00));
        tbl.push_back(v(0,1,1,1,0,0,0,2'b00,2'd3,8'hFE,8'h00,8'h22,8'h50,8'h00, 8'hFE,8'hFE,0,0,8'h00,8'h00));
        tbl.push_back(v(0,0,0,1,0,1,0,2'b01,2'd1,8'hFE,8'h00,8'h00,8'h00,8'h00, 8'h50,8'h50,1,0,8'h50,8'h00));
        tbl.push_back(v(0,0,0,1,0,0,0,2'b01,2'd0,8'hFF,8'h00,8'h00,8'h00,8'h00, 8'h34,8'h34,0,0,8'h34,8'h00));
        tbl.push_back(v(0,0,0,1,0,0,0,2'b01,2'd0,8'hFD,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,8'h00,8'h00));
        tbl.push_back(v(0,0,0,1,1,0,0,2'b00,2'd0,8'h00,8'h7C,8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,8'h00,8'h7C));
        tbl.push_back(v(0,0,0,1,0,1,0,2'b10,2'd3,8'h00,8'h00,8'h00,8'h00,8'h3D, 8'h3D,8'h3D,1,0,8'h00,8'h7C));
        tbl.push_back(v(0,0,0,1,0,1,0,2'b11,2'd2,8'h00,8'h00,8'h99,8'h00,8'h00, 8'h99,8'h99,1,0,8'h00,8'h7C));
        tbl.push_back(v(1,0,0,0,1,1,1,2'b01,2'd1,8'h10,8'hEE,8'h00,8'h00,8'h00, 8'hA5,8'hA5,0,0,8'hA5,8'h7C));
        tbl.push_back(v(0,0,0,1,0,0,0,2'b01,2'd0,8'h10,8'h00,8'h00,8'h00,8'h00, 8'hA5,8'hA5,0,0,8'hA5,8'h7C));
        tbl.push_back(v(1,0,0,1,1,0,0,2'b00,2'd0,8'h20,8'hC3,8'h00,8'h00,8'h00, 8'h20,8'h20,0,0,8'h00,8'hC3));
        tbl.push_back(v(0,0,0,1,0,0,0,2'b01,2'd0,8'h20,8'h00,8'h00,8'h00,8'h00, 8'hC3,8'hC3,0,0,8'hC3,8'hC3));

        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_data", wb_data, 8'h00);
        chk("rst_out_port", out_port, 8'h00);
        chk("rst_ret_valid", {7'd0, ret_valid}, 8'h00);
        chk("rst_regwrite", {7'd0, RegWrite_out}, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // Directed table.
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i], 8'(i), 8'(i) ^ 8'hF0);
            #1 chk($sformatf("v%0d_fwd", i), mem_fwd_data, tbl[i].e_fwd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wb", i), wb_data, tbl[i].e_wb);
            chk($sformatf("v%0d_rw", i), {7'd0, RegWrite_out}, {7'd0, tbl[i].e_rw});
            chk($sformatf("v%0d_rv", i), {7'd0, ret_valid}, {7'd0, tbl[i].e_rv});
            chk($sformatf("v%0d_rpc", i), ret_pc, tbl[i].e_rpc);
            chk($sformatf("v%0d_out", i), out_port, tbl[i].e_out);
            chk($sformatf("v%0d_rdist", i), {6'd0, RegDistidx_out}, {6'd0, tbl[i].rdist});
            chk($sformatf("v%0d_rd1", i), Rd1_out, 8'(i));
            chk($sformatf("v%0d_rd2", i), Rd2_out, 8'(i) ^ 8'hF0);
        end

        // Async reset between edges, with a write pending on the inputs.
        @(negedge clk);
        drive(v(1,0,0,1,1,1,0,2'b01,2'd3,8'h10,8'h5A,8'h00,8'h00,8'h00,
                0,0,0,0,0,0), 8'h11, 8'h22);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_wb_data", wb_data, 8'h00);
        chk("arst_out_port", out_port, 8'h00);
        chk("arst_regwrite", {7'd0, RegWrite_out}, 8'h00);
        chk("arst_rd1", Rd1_out, 8'h00);
        chk("arst_rdist", {6'd0, RegDistidx_out}, 8'h00);
        @(negedge clk);
        idle();
        rst = 1'b1;
        peek("arst_mem10", 8'h10, 8'h00);
        peek("arst_mem20", 8'h20, 8'h00);
        peek("arst_memFF", 8'hFF, 8'h00);
        peek("arst_memFE", 8'hFE, 8'h00);

        // Random traffic against a plain array model of the memory and OUT port.
        for (int a = 0; a < 256; a++) mem_m[a] = 8'h00;
        out_m = 8'h00;
        for (int n = 0; n < 300; n++) begin
            logic [7:0] rd, fwd_e, wd;
            logic [7:0] r1, r2;
            vec_t x;
            x = v(0,0,0,1,0,0,0,2'b00,2'd0,8'h00,8'h00,8'h00,8'h00,8'h00, 0,0,0,0,0,0);
            x.mw    = ($urandom_range(0, 2) == 0);
            x.call  = ($urandom_range(0, 5) == 0);
            x.intr  = ($urandom_range(0, 7) == 0);
            x.nr    = ($urandom_range(0, 4) != 0);
            x.io    = ($urandom_range(0, 3) == 0);
            x.rw    = 1'($urandom);
            x.fl    = ($urandom_range(0, 4) == 0);
            x.m2r   = 2'($urandom);
            x.rdist = 2'($urandom);
            x.alu   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255))
                                                  : 8'($urandom_range(0, 7));
            x.fw    = 8'($urandom);
            x.pc1   = 8'($urandom);
            x.ip    = 8'($urandom);
            x.inp   = 8'($urandom);
            r1      = 8'($urandom);
            r2      = 8'($urandom);

            rd = mem_m[x.alu];
            case (x.m2r)
                2'b00:   fwd_e = x.alu;
                2'b01:   fwd_e = rd;
                2'b10:   fwd_e = x.inp;
                default: fwd_e = x.pc1;
            endcase

            @(negedge clk);
            drive(x, r1, r2);
            #1 chk($sformatf("r%0d_fwd", n), mem_fwd_data, fwd_e);
            @(posedge clk);
            #1;
            if (!x.fl) begin
                if (x.intr)      wd = x.ip;
                else if (x.call) wd = x.pc1;
                else             wd = x.fw;
                if (x.mw || x.call || x.intr) mem_m[x.alu] = wd;
                if (x.io) out_m = x.fw;
            end
            chk($sformatf("r%0d_wb", n), wb_data, fwd_e);
            chk($sformatf("r%0d_rw", n), {7'd0, RegWrite_out}, {7'd0, x.rw && !x.fl});
            chk($sformatf("r%0d_rv", n), {7'd0, ret_valid}, {7'd0, !x.nr && !x.fl});
            chk($sformatf("r%0d_rpc", n), ret_pc, rd);
            chk($sformatf("r%0d_out", n), out_port, out_m);
            chk($sformatf("r%0d_rdist", n), {6'd0, RegDistidx_out}, {6'd0, x.rdist});
            chk($sformatf("r%0d_rd1", n), Rd1_out, r1);
            chk($sformatf("r%0d_rd2", n), Rd2_out, r2);
        end

        // Final sweep of the model's address window.
        for (int a = 0; a < 8; a++) peek($sformatf("sweep_%0d", a), 8'(a), mem_m[a]);
        for (int a = 248; a < 256; a++) peek($sformatf("sweep_%0d", a), 8'(a), mem_m[a]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
